// File: rtl/image_mem_arbiter.sv
// Round-robin arbiter sharing one single-port image memory between a raster write pipe and a read requester.
// Define ARB_WRITE_PRIORITY_EN to make simultaneous requests always favour the write pipe.
module image_mem_arbiter #(
  parameter int PS    = 16,
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int AW    = 12,
  parameter int FC_W  = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr_req,
  input  logic [PS-1:0]   wr_data,
  output logic            wr_ack,
  input  logic            rd_req,
  input  logic [AW-1:0]   rd_addr,
  output logic            rd_ack,
  output logic            rd_valid,
  output logic [PS-1:0]   rd_data,
  output logic            mem_en,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [PS-1:0]   mem_wdata,
  input  logic [PS-1:0]   mem_rdata,
  output logic            frame_done,
  output logic [FC_W-1:0] frame_cnt
);

  // state  | meaning
  // IDLE   | sample wr_req/rd_req and choose the next grant
  // GNT_WR | write strobe on the memory bus, wr_ack high
  // GNT_RD | read strobe on the memory bus, rd_ack high
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_WR = 2'd1,
    GNT_RD = 2'd2
  } state_t;

  typedef enum logic {
    LG_READ  = 1'b0,
    LG_WRITE = 1'b1
  } grant_t;

  localparam int            NPIX     = IMG_W * IMG_H;
  localparam logic [AW-1:0] LAST_PIX = AW'(NPIX - 1);

  state_t        state;
  grant_t        last_grant;
  logic [AW-1:0] wr_ptr;
  logic          rd_oor;
  logic [PS-1:0] rd_data_q;
  logic [PS-1:0] rd_data_now;
  logic          pick_wr;
  logic          rd_in_range;

`ifdef ARB_WRITE_PRIORITY_EN
  assign pick_wr = 1'b1;
`else
  assign pick_wr = (last_grant == LG_READ);
`endif

  assign rd_in_range = (32'(rd_addr) < 32'(NPIX));

  // Memory returns data the cycle after the strobe; present it directly while
  // rd_valid is high and keep a copy so rd_data holds until the next read.
  assign rd_data_now = rd_oor ? '0 : mem_rdata;
  assign rd_data     = rd_valid ? rd_data_now : rd_data_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last_grant <= LG_READ;
      wr_ptr     <= '0;
      rd_oor     <= 1'b0;
      rd_data_q  <= '0;
      wr_ack     <= 1'b0;
      rd_ack     <= 1'b0;
      rd_valid   <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      wr_ack     <= 1'b0;
      rd_ack     <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      frame_done <= 1'b0;
      rd_valid   <= (state == GNT_RD);
      if (rd_valid) begin
        rd_data_q <= rd_data_now;
      end
      case (state)
        IDLE: begin
          if (wr_req && (!rd_req || pick_wr)) begin
            state      <= GNT_WR;
            last_grant <= LG_WRITE;
            mem_en     <= 1'b1;
            mem_we     <= 1'b1;
            mem_addr   <= wr_ptr;
            mem_wdata  <= wr_data;
            wr_ack     <= 1'b1;
            if (wr_ptr == LAST_PIX) begin
              wr_ptr     <= '0;
              frame_done <= 1'b1;
              frame_cnt  <= frame_cnt + 1'b1;
            end else begin
              wr_ptr <= wr_ptr + 1'b1;
            end
          end else if (rd_req) begin
            state      <= GNT_RD;
            last_grant <= LG_READ;
            mem_en     <= rd_in_range;
            mem_addr   <= rd_addr;
            rd_ack     <= 1'b1;
            rd_oor     <= !rd_in_range;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_image_mem_arbiter.sv
// Self-checking bench for image_mem_arbiter: directed vectors, frame wrap, reset, arbitration and a randomized phase.
module tb_image_mem_arbiter;

  localparam int PS   = 16;
  localparam int AW   = 13;
  localparam int FC_W = 8;
  localparam int NPIX = 64 * 64;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            wr_req = 1'b0;
  logic [PS-1:0]   wr_data = '0;
  logic            wr_ack;
  logic            rd_req = 1'b0;
  logic [AW-1:0]   rd_addr = '0;
  logic            rd_ack;
  logic            rd_valid;
  logic [PS-1:0]   rd_data;
  logic            mem_en;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [PS-1:0]   mem_wdata;
  logic [PS-1:0]   mem_rdata = '0;
  logic            frame_done;
  logic [FC_W-1:0] frame_cnt;

  image_mem_arbiter #(.PS(PS), .IMG_W(64), .IMG_H(64), .AW(AW), .FC_W(FC_W)) dut (
    .clk(clk), .reset(reset),
    .wr_req(wr_req), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM: read data appears the cycle after the strobe.
  logic [PS-1:0] ram [8192];
  logic          ram_clear = 1'b0;
  always @(posedge clk) begin
    if (ram_clear) begin
      for (int i = 0; i < 8192; i++) ram[i] <= '0;
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int fd_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_ack(input bit is_wr, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (frame_done) fd_seen++;
      if ((is_wr && wr_ack) || (!is_wr && rd_ack)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk(is_wr ? "wr_ack_timeout" : "rd_ack_timeout", 32'(0), 32'(1));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_wr_ack"}, 32'(wr_ack), 32'(0));
    chk({tag, "_rd_ack"}, 32'(rd_ack), 32'(0));
    chk({tag, "_rd_valid"}, 32'(rd_valid), 32'(0));
    chk({tag, "_rd_data"}, 32'(rd_data), 32'(0));
    chk({tag, "_mem_en"}, 32'(mem_en), 32'(0));
    chk({tag, "_mem_we"}, 32'(mem_we), 32'(0));
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'(0));
    chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'(0));
    chk({tag, "_frame_done"}, 32'(frame_done), 32'(0));
    chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(0));
  endtask

  task automatic apply_reset(input string tag, input bit clear_ram);
    wr_req = 1'b0;
    rd_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    ram_clear = clear_ram;
    #1;
    check_reset_outputs(tag);
    @(negedge clk);
    ram_clear = 1'b0;
    check_reset_outputs(tag);
    reset = 1'b1;
  endtask

  task automatic do_write(input logic [PS-1:0] data, input logic [AW-1:0] exp_addr);
    bit ok;
    wr_req  = 1'b1;
    wr_data = data;
    wait_ack(1'b1, ok);
    if (ok) begin
      chk("wr_mem_en", 32'(mem_en), 32'(1));
      chk("wr_mem_we", 32'(mem_we), 32'(1));
      chk("wr_mem_addr", 32'(mem_addr), 32'(exp_addr));
      chk("wr_mem_wdata", 32'(mem_wdata), 32'(data));
    end
    wr_req = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input bit exp_en, input logic [PS-1:0] exp_data);
    bit ok;
    rd_req  = 1'b1;
    rd_addr = addr;
    wait_ack(1'b0, ok);
    if (ok) begin
      chk("rd_mem_en", 32'(mem_en), 32'(exp_en));
      chk("rd_mem_we", 32'(mem_we), 32'(0));
      chk("rd_valid_early", 32'(rd_valid), 32'(0));
      if (exp_en) chk("rd_mem_addr", 32'(mem_addr), 32'(addr));
    end
    rd_req = 1'b0;
    @(negedge clk);
    chk("rd_valid", 32'(rd_valid), 32'(1));
    chk("rd_data", 32'(rd_data), 32'(exp_data));
  endtask

  // wr_req held high for n items; each ack checked against the raster address.
  task automatic write_burst(input int n, input int first_addr);
    bit ok;
    int a;
    wr_req  = 1'b1;
    wr_data = PS'(first_addr);
    for (int i = 0; i < n; i++) begin
      a = (first_addr + i) % NPIX;
      wait_ack(1'b1, ok);
      if (!ok) break;
      chk("burst_addr", 32'(mem_addr), 32'(a));
      chk("burst_fd", 32'(frame_done), 32'(a == NPIX - 1));
      wr_data = PS'(first_addr + i + 1);
    end
    wr_req = 1'b0;
  endtask

  typedef struct {
    bit            is_wr;
    logic [PS-1:0] data;
    logic [AW-1:0] addr;
    bit            exp_en;
    logic [PS-1:0] exp_rd;
  } vec_t;

  vec_t vecs[10];
  logic [PS-1:0] ref_mem [8192];

  initial begin
    bit ok;
    int t_ack [3];
    bit exp_w;
    bit lw, pend, gw, gr, in_rng, prev_w, prev_r, prev_grant;
    int ptr, frames;
    logic [PS-1:0] pexp;

    vecs[0] = '{1'b1, 16'h4444, 13'd3,    1'b1, 16'h0000};
    vecs[1] = '{1'b1, 16'h5555, 13'd4,    1'b1, 16'h0000};
    vecs[2] = '{1'b1, 16'h00AB, 13'd5,    1'b1, 16'h0000};
    vecs[3] = '{1'b0, 16'h0000, 13'd5,    1'b1, 16'h00AB};
    vecs[4] = '{1'b0, 16'h0000, 13'd1,    1'b1, 16'h2222};
    vecs[5] = '{1'b0, 16'h0000, 13'd0,    1'b1, 16'h1111};
    vecs[6] = '{1'b0, 16'h0000, 13'd4100, 1'b0, 16'h0000};
    vecs[7] = '{1'b0, 16'h0000, 13'd4095, 1'b1, 16'h0000};
    vecs[8] = '{1'b1, 16'h7777, 13'd6,    1'b1, 16'h0000};
    vecs[9] = '{1'b0, 16'h0000, 13'd6,    1'b1, 16'h7777};

    apply_reset("rst0", 1'b1);

    // Three back-to-back writes: addresses 0,1,2, grants two cycles apart.
    wr_req  = 1'b1;
    wr_data = 16'h1111;
    for (int i = 0; i < 3; i++) begin
      wait_ack(1'b1, ok);
      t_ack[i] = cyc;
      chk("seq_addr", 32'(mem_addr), 32'(i));
      chk("seq_we", 32'(mem_we), 32'(1));
      chk("seq_wdata", 32'(mem_wdata), 32'(16'h1111 * (i + 1)));
      wr_data = PS'(16'h1111 * (i + 2));
    end
    wr_req = 1'b0;
    chk("seq_gap1", 32'(t_ack[1] - t_ack[0]), 32'(2));
    chk("seq_gap2", 32'(t_ack[2] - t_ack[1]), 32'(2));

    for (int v = 0; v < 10; v++) begin
      if (vecs[v].is_wr) do_write(vecs[v].data, vecs[v].addr);
      else               do_read(vecs[v].addr, vecs[v].exp_en, vecs[v].exp_rd);
    end
    repeat (3) @(negedge clk);
    chk("rd_data_hold", 32'(rd_data), 32'(16'h7777));

    // Full frame after reset.
    apply_reset("rst1", 1'b0);
    fd_seen = 0;
    write_burst(NPIX, 0);
    chk("frame_done_once", 32'(fd_seen), 32'(1));
    chk("frame_cnt_1", 32'(frame_cnt), 32'(1));
    do_write(16'hCAFE, 13'd0);
    chk("frame_cnt_hold", 32'(frame_cnt), 32'(1));

    // Mid-frame reset discards the partial frame and the frame count.
    write_burst(100, 1);
    apply_reset("rst2", 1'b0);
    do_write(16'hBEEF, 13'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'(0));

    // Both requests held: alternation starting with write (or writes only).
    apply_reset("rst3", 1'b0);
    wr_req  = 1'b1;
    wr_data = 16'h0F0F;
    rd_req  = 1'b1;
    rd_addr = '0;
    for (int i = 0; i < 8; i++) begin
      ok = 1'b0;
      for (int j = 0; j < 10; j++) begin
        @(negedge clk);
        if (wr_ack || rd_ack) begin ok = 1'b1; break; end
      end
      chk("alt_grant_seen", 32'(ok), 32'(1));
`ifdef ARB_WRITE_PRIORITY_EN
      exp_w = 1'b1;
`else
      exp_w = (i % 2 == 0);
`endif
      chk("alt_kind", 32'(wr_ack), 32'(exp_w));
    end
    wr_req = 1'b0;
    rd_req = 1'b0;

    // Randomized phase against a transaction-level model.
    apply_reset("rst4", 1'b1);
    for (int i = 0; i < 8192; i++) ref_mem[i] = '0;
    lw = 1'b0; pend = 1'b0; prev_w = 1'b0; prev_r = 1'b0; prev_grant = 1'b0;
    ptr = 0; frames = 0; pexp = '0;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      if (pend) begin
        chk("r_rd_valid", 32'(rd_valid), 32'(1));
        chk("r_rd_data", 32'(rd_data), 32'(pexp));
        pend = 1'b0;
      end else begin
        chk("r_rd_valid_idle", 32'(rd_valid), 32'(0));
      end
      gw = wr_ack;
      gr = rd_ack;
      chk("r_single_grant", 32'(gw & gr), 32'(0));
      if (prev_grant) chk("r_gap", 32'(gw | gr), 32'(0));
      else if (prev_w || prev_r) chk("r_no_stall", 32'(gw | gr), 32'(1));
      if (prev_w && prev_r && (gw || gr)) begin
`ifdef ARB_WRITE_PRIORITY_EN
        exp_w = 1'b1;
`else
        exp_w = !lw;
`endif
        chk("r_arb_choice", 32'(gw), 32'(exp_w));
      end
      if (gw) begin
        chk("r_wr_req_was_high", 32'(prev_w), 32'(1));
        chk("r_wr_addr", 32'(mem_addr), 32'(ptr));
        chk("r_wr_en_we", 32'({mem_en, mem_we}), 32'(2'b11));
        chk("r_wr_wdata", 32'(mem_wdata), 32'(wr_data));
        chk("r_frame_done", 32'(frame_done), 32'(ptr == NPIX - 1));
        ref_mem[ptr] = wr_data;
        if (ptr == NPIX - 1) begin ptr = 0; frames++; end
        else ptr++;
        chk("r_frame_cnt", 32'(frame_cnt), 32'(frames % 256));
        lw = 1'b1;
      end else begin
        chk("r_frame_done_idle", 32'(frame_done), 32'(0));
      end
      if (gr) begin
        chk("r_rd_req_was_high", 32'(prev_r), 32'(1));
        in_rng = (int'(rd_addr) < NPIX);
        chk("r_rd_en", 32'(mem_en), 32'(in_rng));
        chk("r_rd_we", 32'(mem_we), 32'(0));
        pexp = in_rng ? ref_mem[rd_addr] : '0;
        pend = 1'b1;
        lw = 1'b0;
      end
      prev_grant = gw | gr;
      if (gw) begin
        if ($urandom_range(1) == 1) wr_data = PS'($urandom);
        else wr_req = 1'b0;
      end else if (!wr_req && $urandom_range(2) == 0) begin
        wr_req  = 1'b1;
        wr_data = PS'($urandom);
      end
      if (gr) begin
        if ($urandom_range(1) == 1) rd_addr = AW'($urandom_range(0, 4300));
        else rd_req = 1'b0;
      end else if (!rd_req && $urandom_range(2) == 0) begin
        rd_req  = 1'b1;
        rd_addr = (ptr > 0 && $urandom_range(1) == 1) ? AW'($urandom_range(0, ptr - 1))
                                                      : AW'($urandom_range(0, 4300));
      end
      prev_w = wr_req;
      prev_r = rd_req;
    end
    wr_req = 1'b0;
    rd_req = 1'b0;
    if (pend) begin
      @(negedge clk);
      chk("r_rd_valid_last", 32'(rd_valid), 32'(1));
      chk("r_rd_data_last", 32'(rd_data), 32'(pexp));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/image_mem_arbiter.md
Name: image_mem_arbiter

Overview:
- Shares the single-port image memory between two requesters:
  - the posit write pipe coming out of the integer-to-posit converter;
  - a read requester used by the downstream processing engine.
- Generates sequential raster write addresses, counts completed frames and arbitrates round-robin.
- Sits between the converter's req/ack write pipe and the image memory.

Parameters:
PS, 16, posit word width (write/read data width)
IMG_W, 64, image width in pixels
IMG_H, 64, image height in pixels
AW, 12, memory address width; must satisfy 2^AW >= IMG_W*IMG_H
FC_W, 8, frame counter width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
wr_req  in  1  write pipe request; wr_data valid while high
wr_data  in  PS  posit pixel to store
wr_ack  out  1  one-cycle pulse: write committed
rd_req  in  1  read request; rd_addr valid while high
rd_addr  in  AW  read address
rd_ack  out  1  one-cycle pulse: read request accepted
rd_valid  out  1  one-cycle pulse: rd_data valid
rd_data  out  PS  read data
mem_en  out  1  memory enable
mem_we  out  1  memory write enable
mem_addr  out  AW  memory address
mem_wdata  out  PS  memory write data
mem_rdata  in  PS  memory read data, 1-cycle latency after mem_en
frame_done  out  1  one-cycle pulse on last pixel of a frame
frame_cnt  out  FC_W  completed frame count, wraps modulo 2^FC_W

Behaviour:
- Reset (reset=0, asynchronous) clears all registered outputs to 0: wr_ack, rd_ack, rd_valid, rd_data, mem_en, mem_we, mem_addr, mem_wdata, frame_done and frame_cnt. Reset also forces wr_ptr=0, state=IDLE and last_grant=READ.
- Reset mid-frame discards the partial frame; the next accepted write goes to address 0.
- FSM states:
  - IDLE:
    - samples wr_req and rd_req;
    - only wr_req -> GNT_WR; only rd_req -> GNT_RD;
    - both -> grant the requester not in last_grant (round-robin);
    - neither -> stay in IDLE.
  - GNT_WR (one cycle, outputs registered on entry):
    - drives mem_en=1, mem_we=1, mem_addr=wr_ptr, mem_wdata=wr_data as sampled in IDLE;
    - drives wr_ack=1;
    - sets last_grant=WRITE;
    - -> IDLE.
  - GNT_RD (one cycle):
    - drives mem_en=1, mem_we=0, mem_addr=rd_addr as sampled, rd_ack=1;
    - sets last_grant=READ;
    - -> IDLE.
- Read data timing:
  - rd_valid pulses the cycle after GNT_RD;
  - rd_data = registered mem_rdata capture, valid while rd_valid=1 and held until the next read completes.
- Out-of-range read (rd_addr >= IMG_W*IMG_H):
  - still acknowledged with rd_ack;
  - mem_en=0 (no memory access);
  - rd_valid pulses the following cycle with rd_data=0.
- Throughput: at most one transaction per 2 cycles. A requester whose req stays high after its ack is treated as presenting a new item.
- Handshake: the requester must hold data/address stable while req is high, and update or drop req on the edge where it samples ack=1.
- wr_ptr:
  - increments by 1 on each GNT_WR;
  - at IMG_W*IMG_H-1 it wraps to 0;
  - in that same GNT_WR cycle frame_done=1 and frame_cnt increments.
- mem_en, mem_we, wr_ack and rd_ack return to 0 in every non-grant cycle. mem_addr and mem_wdata hold their last value.
- A read and a write to the same address are never simultaneous (single grant per cycle). Ordering is the grant order.

Optional Feature:
- Macro: ARB_WRITE_PRIORITY_EN.
- Defined: IDLE with both requests always grants the write; last_grant is ignored. This keeps the converter stream from stalling at the cost of read starvation during continuous writes.
- Undefined: round-robin as above.

Test Plan:
- Reset release, 3 writes 0x1111/0x2222/0x3333 with rd_req=0 -> mem_addr 0,1,2, mem_we=1 in each grant cycle, 3 wr_ack pulses, grants 2 cycles apart.
- Write 4096 pixels (64x64) -> frame_done pulses exactly once, with the 4096th wr_ack at mem_addr=4095; frame_cnt=1; the next write goes to mem_addr=0.
- wr_req and rd_req both held high continuously -> grants alternate W,R,W,R starting with W. With ARB_WRITE_PRIORITY_EN defined, only writes are granted.
- rd_addr=5 after writing 0x00AB to address 5 -> rd_ack, then the next cycle rd_valid=1 with rd_data=0x00AB.
- rd_addr=4100 -> rd_ack=1 with mem_en=0, then rd_valid=1 with rd_data=0.
- Assert reset after 100 writes, release, write 1 pixel -> all outputs 0 during reset, frame_cnt=0, the new write lands at mem_addr=0.
